// File: rtl/fsm_arb_pkg.sv
// Shared types and code tables for the arbiter that steers an external 3-state FSM.
// Targets S0..S2 map to a returned state code and to an {a,b} drive code.
package fsm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

    localparam logic [1:0] TGT_S0  = 2'd0;
    localparam logic [1:0] TGT_S1  = 2'd1;
    localparam logic [1:0] TGT_S2  = 2'd2;
    localparam logic [1:0] TGT_BAD = 2'd3;

    localparam logic [2:0] DOUT_S0   = 3'b001;
    localparam logic [2:0] DOUT_S1   = 3'b010;
    localparam logic [2:0] DOUT_S2   = 3'b011;
    localparam logic [2:0] DOUT_NONE = 3'b111;

    localparam logic [1:0] DRV_S0   = 2'b10;
    localparam logic [1:0] DRV_S1   = 2'b01;
    localparam logic [1:0] DRV_S2   = 2'b11;
    localparam logic [1:0] DRV_HOLD = 2'b00;

    function automatic logic tgt_legal(input logic [1:0] t);
        return (t != TGT_BAD);
    endfunction

    function automatic logic [2:0] dout_code(input logic [1:0] t);
        case (t)
            TGT_S0:  return DOUT_S0;
            TGT_S1:  return DOUT_S1;
            TGT_S2:  return DOUT_S2;
            default: return DOUT_NONE;
        endcase
    endfunction

    function automatic logic [1:0] drive_code(input logic [1:0] t);
        case (t)
            TGT_S0:  return DRV_S0;
            TGT_S1:  return DRV_S1;
            TGT_S2:  return DRV_S2;
            default: return DRV_HOLD;
        endcase
    endfunction

    function automatic logic dout_legal(input logic [2:0] d);
        case (d)
            DOUT_S0, DOUT_S1, DOUT_S2: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request found searching upward from ptr, wrapping.
// Produces a one-hot grant, its index and a valid flag.
module rr_priority_picker #(
    parameter  int N_REQ = 3,
    localparam int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    idx,
    output logic             valid
);

    int            pos;
    logic [PW-1:0] cand;
    logic          hit;

    // Walk the ring from ptr; only the first hit sets the grant.
    always_comb begin
        grant = {N_REQ{1'b0}};
        idx   = {PW{1'b0}};
        valid = 1'b0;
        pos   = 0;
        cand  = {PW{1'b0}};
        hit   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            pos         = int'(ptr) + k;
            pos         = (pos >= N_REQ) ? (pos - N_REQ) : pos;
            cand        = PW'(pos);
            hit         = req[cand] & ~valid;
            grant[cand] = grant[cand] | hit;
            idx         = hit ? cand : idx;
            valid       = valid | hit;
        end
    end

endmodule

// File: rtl/fsm_state_arbiter.sv
// Arbitrates requesters that each want the external 3-state FSM moved to a target,
// drives {a,b} until the returned code matches or the cycle budget runs out.
module fsm_state_arbiter
    import fsm_arb_pkg::*;
#(
    parameter  int N_REQ   = 3,
    parameter  int TIMEOUT = 7,
    localparam int PW      = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] tgt,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   err,
    output logic               busy,
    output logic [PW-1:0]      owner,
    output logic               a,
    output logic               b,
    input  logic [2:0]         dout
);

    // cnt_r holds completed DRIVE cycles, so the TIMEOUT-th cycle is the last one.
    localparam logic [7:0]       CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [PW-1:0]    IDX_LAST = PW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ - 1){1'b0}}, 1'b1};

    arb_state_t       state_r;
    arb_state_t       state_s;
    logic [PW-1:0]    ptr_r;
    logic [PW-1:0]    owner_r;
    logic [PW-1:0]    win_s;
    logic [1:0]       tgt_r;
    logic [1:0]       tgt_sel_s;
    logic [7:0]       cnt_r;
    logic             a_r;
    logic             b_r;
    logic             busy_r;
    logic [N_REQ-1:0] ack_r;
    logic [N_REQ-1:0] err_r;
    logic [N_REQ-1:0] pick_grant_s;
    logic [PW-1:0]    pick_idx_s;
    logic             pick_valid_s;
    logic             grant_s;
    logic             ok_s;
    logic             fail_s;
    logic             match_s;
    logic [1:0]       drv_s;

    rr_priority_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Target field of the winning requester.
    always_comb begin
        tgt_sel_s = 2'b00;
        for (int i = 0; i < N_REQ; i++) begin
            tgt_sel_s = tgt_sel_s | (tgt[2*i +: 2] & {2{pick_grant_s[i]}});
        end
    end

    assign match_s = dout_legal(dout) && (dout == dout_code(tgt_r));

    // Next state, completion status and next drive code.
    always_comb begin
        state_s = state_r;
        grant_s = 1'b0;
        ok_s    = 1'b0;
        fail_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    grant_s = 1'b1;
                    if (tgt_legal(tgt_sel_s)) begin
                        state_s = ST_DRIVE;
                    end else begin
                        state_s = ST_DONE;
                        fail_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (match_s) begin
                    state_s = ST_DONE;
                    ok_s    = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                    fail_s  = 1'b1;
                end else begin
                    state_s = ST_DRIVE;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        win_s = grant_s ? pick_idx_s : owner_r;
        drv_s = (state_s == ST_DRIVE) ? drive_code(grant_s ? tgt_sel_s : tgt_r) : DRV_HOLD;
    end

    // State and registered outputs; a reset mid-operation drops any pending pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= {PW{1'b0}};
            owner_r <= {PW{1'b0}};
            tgt_r   <= 2'b00;
            cnt_r   <= 8'd0;
            a_r     <= 1'b0;
            b_r     <= 1'b0;
            busy_r  <= 1'b0;
            ack_r   <= {N_REQ{1'b0}};
            err_r   <= {N_REQ{1'b0}};
        end else begin
            state_r    <= state_s;
            busy_r     <= (state_s != ST_IDLE);
            {a_r, b_r} <= drv_s;
            ack_r      <= ok_s   ? (ONE_HOT0 << win_s) : {N_REQ{1'b0}};
            err_r      <= fail_s ? (ONE_HOT0 << win_s) : {N_REQ{1'b0}};
            if (grant_s) begin
                owner_r <= pick_idx_s;
                tgt_r   <= tgt_sel_s;
                cnt_r   <= 8'd0;
            end else if (state_r == ST_DRIVE) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            if (state_r == ST_DONE) begin
                ptr_r <= (owner_r == IDX_LAST) ? {PW{1'b0}} : (owner_r + PW'(1'b1));
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign ack   = ack_r;
    assign err   = err_r;
    assign busy  = busy_r;
    assign owner = owner_r;
    assign a     = a_r;
    assign b     = b_r;

endmodule

// File: tb/tb_fsm_state_arbiter.sv
// Directed bench: the arbiter drives a behavioural model of the 3-state FSM; outputs
// are sampled on the falling edge and compared with hand-derived values.
module tb_fsm_state_arbiter;

    localparam int N_REQ   = 3;
    localparam int TIMEOUT = 7;
    localparam int PW      = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_REQ-1:0]   req;
    logic [2*N_REQ-1:0] tgt;
    logic [N_REQ-1:0]   ack;
    logic [N_REQ-1:0]   err;
    logic               busy;
    logic [PW-1:0]      owner;
    logic               a;
    logic               b;
    logic [2:0]         dout;
    logic [1:0]         m_state;
    logic [2:0]         m_code;
    logic               stuck;
    int                 n_pass  = 0;
    int                 n_total = 0;

    always #5 clk = ~clk;

    fsm_state_arbiter #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .tgt   (tgt),
        .ack   (ack),
        .err   (err),
        .busy  (busy),
        .owner (owner),
        .a     (a),
        .b     (b),
        .dout  (dout)
    );

    // Controlled FSM: {a,b} 10->S0, 01->S1, 11->S2, 00 holds; resets to S0.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_state <= 2'd0;
        end else begin
            case ({a, b})
                2'b10:   m_state <= 2'd0;
                2'b01:   m_state <= 2'd1;
                2'b11:   m_state <= 2'd2;
                default: m_state <= m_state;
            endcase
        end
    end

    always_comb begin
        case (m_state)
            2'd0:    m_code = 3'b001;
            2'd1:    m_code = 3'b010;
            2'd2:    m_code = 3'b011;
            default: m_code = 3'b000;
        endcase
        dout = stuck ? 3'b000 : m_code;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b000;
        tgt   = 6'b000000;
        stuck = 1'b0;
        tick();
        tick();
        chk("rst_busy",  32'(busy),   32'h0);
        chk("rst_owner", 32'(owner),  32'h0);
        chk("rst_ab",    32'({a, b}), 32'h0);
        chk("rst_ack",   32'(ack),    32'h0);
        chk("rst_err",   32'(err),    32'h0);
        rst_n = 1'b1;
        tick();

        // All three request: tgt0=S0, tgt1=S1, tgt2=S2; order must be 0,1,2.
        req = 3'b111;
        tgt = 6'b10_01_00;
        tick();
        chk("rr0_owner", 32'(owner),  32'h0);
        chk("rr0_ab",    32'({a, b}), 32'h2);
        chk("rr0_busy",  32'(busy),   32'h1);
        tick();
        chk("rr0_ack",   32'(ack),    32'h1);
        req = 3'b110;
        tick();
        chk("rr_gap_ack",  32'(ack),  32'h0);
        chk("rr_gap_busy", 32'(busy), 32'h0);
        tick();
        chk("rr1_owner", 32'(owner),  32'h1);
        chk("rr1_ab",    32'({a, b}), 32'h1);
        tick();
        tick();
        chk("rr1_ack",   32'(ack),    32'h2);
        req = 3'b100;
        tick();
        tick();
        chk("rr2_owner", 32'(owner),  32'h2);
        chk("rr2_ab",    32'({a, b}), 32'h3);
        tick();
        tick();
        chk("rr2_ack",   32'(ack),    32'h4);
        req = 3'b000;
        tick();
        chk("rr_end_busy", 32'(busy), 32'h0);

        // Pointer wrapped to 0: with req=101 requester 0 must win before 2.
        req = 3'b101;
        tgt = 6'b00_00_00;
        tick();
        chk("wrap_owner", 32'(owner),  32'h0);
        chk("wrap_ab",    32'({a, b}), 32'h2);
        tick();
        tick();
        chk("wrap_ack0",  32'(ack),    32'h1);
        req = 3'b100;
        tick();
        tick();
        chk("wrap_owner2", 32'(owner), 32'h2);
        tick();
        chk("wrap_ack2",  32'(ack),    32'h4);
        req = 3'b000;
        tick();

        // Single request to S2 from S0: a=b=1 in cycle 1, ack in cycle 3.
        req = 3'b001;
        tgt = 6'b00_00_10;
        tick();
        chk("s2_ab_c1",  32'({a, b}), 32'h3);
        chk("s2_ack_c1", 32'(ack),    32'h0);
        tick();
        chk("s2_ab_c2",  32'({a, b}), 32'h3);
        chk("s2_ack_c2", 32'(ack),    32'h0);
        tick();
        chk("s2_ack_c3", 32'(ack),    32'h1);
        chk("s2_err_c3", 32'(err),    32'h0);
        chk("s2_ab_c3",  32'({a, b}), 32'h0);
        req = 3'b000;
        tick();
        chk("s2_ack_c4", 32'(ack),     32'h0);
        chk("s2_model",  32'(m_state), 32'h2);

        // dout stuck at 000: seven DRIVE cycles, then a one-cycle err.
        stuck = 1'b1;
        req   = 3'b001;
        tgt   = 6'b00_00_01;
        tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            chk("tmo_ab",  32'({a, b}), 32'h1);
            chk("tmo_err", 32'(err),    32'h0);
            tick();
        end
        chk("tmo_err_pulse", 32'(err),    32'h1);
        chk("tmo_no_ack",    32'(ack),    32'h0);
        chk("tmo_ab_done",   32'({a, b}), 32'h0);
        req = 3'b000;
        tick();
        chk("tmo_err_clr", 32'(err),  32'h0);
        chk("tmo_idle",    32'(busy), 32'h0);
        stuck = 1'b0;

        // Illegal target 3 on requester 1: straight to DONE with err, never driven.
        req = 3'b010;
        tgt = 6'b00_11_00;
        tick();
        chk("bad_err",   32'(err),    32'h2);
        chk("bad_ack",   32'(ack),    32'h0);
        chk("bad_ab",    32'({a, b}), 32'h0);
        chk("bad_owner", 32'(owner),  32'h1);
        req = 3'b000;
        tick();
        chk("bad_err_clr", 32'(err),    32'h0);
        chk("bad_ab2",     32'({a, b}), 32'h0);

        // Reset in the second DRIVE cycle aborts silently and clears the pointer.
        req = 3'b001;
        tgt = 6'b00_00_10;
        tick();
        chk("rst_mid_ab_c1", 32'({a, b}), 32'h3);
        tick();
        chk("rst_mid_busy_c2", 32'(busy), 32'h1);
        rst_n = 1'b0;
        req   = 3'b000;
        tick();
        chk("rst_mid_busy",  32'(busy),   32'h0);
        chk("rst_mid_ab",    32'({a, b}), 32'h0);
        chk("rst_mid_ack",   32'(ack),    32'h0);
        chk("rst_mid_err",   32'(err),    32'h0);
        chk("rst_mid_owner", 32'(owner),  32'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_mid_ack2", 32'(ack), 32'h0);
        chk("rst_mid_err2", 32'(err), 32'h0);
        // ptr=0 gives requester 1 priority over 2.
        req = 3'b110;
        tgt = 6'b01_01_00;
        tick();
        chk("rst_ptr_owner", 32'(owner),  32'h1);
        chk("rst_ptr_ab",    32'({a, b}), 32'h1);
        tick();
        tick();
        chk("rst_ptr_ack1",  32'(ack),    32'h2);
        req = 3'b100;
        tick();
        tick();
        chk("rst_ptr_owner2", 32'(owner), 32'h2);
        tick();
        chk("rst_ptr_ack2",  32'(ack),    32'h4);
        req = 3'b000;
        tick();

        // Request dropped mid-DRIVE still completes and acks.
        req = 3'b001;
        tgt = 6'b00_00_10;
        tick();
        chk("drop_ab",    32'({a, b}), 32'h3);
        chk("drop_owner", 32'(owner),  32'h0);
        req = 3'b000;
        tick();
        chk("drop_busy",  32'(busy), 32'h1);
        chk("drop_ack_c2", 32'(ack), 32'h0);
        tick();
        chk("drop_ack",   32'(ack), 32'h1);
        tick();
        chk("drop_ack_clr", 32'(ack),     32'h0);
        chk("drop_idle",    32'(busy),    32'h0);
        chk("drop_model",   32'(m_state), 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
